// File: rtl/ab_pattern_tx.sv
// Transmit side of the {a,b} symbol link: sends a SYM_COUNT-symbol frame, then one recovery symbol.
// Define AB_TX_CHECK_EN to compare y0/y1 against an internal mirror of the detector and flag err.
module ab_pattern_tx #(
  parameter int SYM_COUNT = 8,
  parameter int CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2*SYM_COUNT-1:0] cmd_pattern,
  output logic                   a,
  output logic                   b,
  input  logic                   y0,
  input  logic                   y1,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       hit_count,
  output logic                   err
);

  localparam int IDX_W = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_COUNT - 1);
  localparam logic [1:0] M_S0 = 2'b00;
  localparam logic [1:0] M_S1 = 2'b01;
  localparam logic [1:0] M_S2 = 2'b10;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t                 state, state_next;
  logic [2*SYM_COUNT-1:0] shift_reg;
  logic [IDX_W-1:0]       sym_idx;
  logic [1:0]             mirror, mirror_next;
  logic                   accept, last_sym;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    cmd_ready  = (state == IDLE);
    busy       = (state == SEND) || (state == DRAIN);
    done       = (state == DONE);
    accept     = cmd_valid && (state == IDLE);
    last_sym   = (sym_idx == LAST_IDX);
    case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last_sym) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Detector next-state rule applied to the symbol currently on the wires
  always_comb begin
    mirror_next = M_S0;
    case (mirror)
      M_S0:    mirror_next = (a && b) ? M_S2 : (a ? M_S1 : M_S0);
      M_S1:    mirror_next = a ? M_S0 : M_S1;
      M_S2:    mirror_next = M_S0;
      default: mirror_next = M_S0;
    endcase
  end

  // Symbol shifter; the recovery symbol is picked from where the detector will be after the last symbol
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      sym_idx   <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      mirror    <= M_S0;
    end else begin
      mirror <= mirror_next;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= cmd_pattern >> 2;
            a         <= cmd_pattern[1];
            b         <= cmd_pattern[0];
            sym_idx   <= '0;
          end else begin
            a <= 1'b0;
            b <= 1'b0;
          end
        end
        SEND: begin
          if (last_sym) begin
            a <= (mirror_next == M_S1);
            b <= 1'b0;
          end else begin
            a         <= shift_reg[1];
            b         <= shift_reg[0];
            shift_reg <= shift_reg >> 2;
            sym_idx   <= sym_idx + IDX_W'(1);
          end
        end
        default: begin
          a <= 1'b0;
          b <= 1'b0;
        end
      endcase
    end
  end

  // Saturating hit counter, cleared when a frame is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
    end else if (accept) begin
      hit_count <= '0;
    end else if (busy && y0 && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + CNT_W'(1);
    end
  end

`ifdef AB_TX_CHECK_EN
  logic exp_y0, exp_y1, mismatch;

  always_comb begin
    exp_y0   = (mirror == M_S0) && a && b;
    exp_y1   = (mirror == M_S0) || (mirror == M_S1);
    mismatch = busy && ((y0 != exp_y0) || (y1 != exp_y1));
  end

  // Sticky error, cleared only on the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err <= 1'b0;
    else if (accept)   err <= 1'b0;
    else if (mismatch) err <= 1'b1;
  end
`else
  logic unused_y1;
  assign unused_y1 = y1;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ab_pattern_tx.sv
// Randomized scoreboard bench for ab_pattern_tx with a behavioural detector attached.
module tb_ab_pattern_tx;

  localparam int SYM = 8;
  localparam int PW  = 2 * SYM;

  typedef struct {
    logic [2*SYM+1:0] stream;
    int               hits;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_ready, a, b, y0, y1, busy, done, err;
  logic [PW-1:0] cmd_pattern;
  logic [3:0]    hit_count;
  logic y1_stuck;

  logic cmd_ready_s, a_s, b_s, y0_s, y1_s, busy_s, done_s, err_s;
  logic [1:0] hit_count_s;

  int n_vec = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ab_pattern_tx #(.SYM_COUNT(SYM), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .a(a), .b(b), .y0(y0), .y1(y1),
    .busy(busy), .done(done), .hit_count(hit_count), .err(err));

  ab_pattern_tx #(.SYM_COUNT(SYM), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
    .cmd_pattern(cmd_pattern), .a(a_s), .b(b_s), .y0(y0_s), .y1(y1_s),
    .busy(busy_s), .done(done_s), .hit_count(hit_count_s), .err(err_s));

  function automatic int det_next(int s, bit sa, bit sb_);
    case (s)
      0:       return (sa && sb_) ? 2 : (sa ? 1 : 0);
      1:       return sa ? 0 : 1;
      default: return 0;
    endcase
  endfunction

  // Reference detectors (S0=0, S1=1, S2=2) driven by each transmitter
  int ds, ds_s;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds   <= 0;
      ds_s <= 0;
    end else begin
      ds   <= det_next(ds, a, b);
      ds_s <= det_next(ds_s, a_s, b_s);
    end
  end
  assign y0   = (ds == 0) && a && b;
  assign y1   = (ds <= 1) && !y1_stuck;
  assign y0_s = (ds_s == 0) && a_s && b_s;
  assign y1_s = (ds_s <= 1);

  function automatic exp_t model(logic [PW-1:0] pat, bit fault);
    exp_t e;
    int s = 0;
    e.stream = '0;
    e.hits   = 0;
    for (int i = 0; i < SYM; i++) begin
      bit sa = pat[2*i+1];
      bit sb_ = pat[2*i];
      e.stream[2*i+1] = sa;
      e.stream[2*i]   = sb_;
      if (s == 0 && sa && sb_) e.hits++;
      s = det_next(s, sa, sb_);
    end
    e.stream[2*SYM+1] = (s == 1);
    e.stream[2*SYM]   = 1'b0;
`ifdef AB_TX_CHECK_EN
    e.err = fault;
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [PW-1:0] pat, input bit keep, input bit b2b);
    int w = 0;
    cmd_pattern = pat;
    cmd_valid   = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!cmd_ready && w < 60);
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (b2b) checkOutput("b2b_gap", 32'(w), 32'(SYM + 3));
    sb.push_back(model(pat, y1_stuck));
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    int w = 0;
    while (!done && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_ab"}, 32'({a, b}), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_hits"}, 32'(hit_count), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Monitor: captures each frame on a/b and pops the scoreboard at the done pulse
  int cyc = 0, acc_cyc = 0, k = 0;
  bit active = 0, hold_chk = 0;
  logic [2*SYM+1:0] cap;
  exp_t last_e, e;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        active   = 0;
        hold_chk = 0;
        continue;
      end
      if (hold_chk) begin
        checkOutput("hold_hits", 32'(hit_count), 32'(last_e.hits));
        checkOutput("hold_err", 32'(err), 32'(last_e.err));
        hold_chk = 0;
      end
      if (active) begin
        if (cmd_ready) checkOutput("ready_while_busy", 32'(cmd_ready), 32'd0);
        if (busy && k <= SYM) begin
          cap[2*k+1] = a;
          cap[2*k]   = b;
          k++;
        end
        if (done) begin
          active = 0;
          if (sb.size() == 0) begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            checkOutput("latency", 32'(cyc - acc_cyc), 32'(SYM + 2));
            checkOutput("sym_count", 32'(k), 32'(SYM + 1));
            checkOutput("stream", 32'(cap), 32'(e.stream));
            checkOutput("done_ab", 32'({a, b}), 32'd0);
            checkOutput("hit_count", 32'(hit_count), 32'(e.hits));
            checkOutput("hit_sat", 32'(hit_count_s), 32'((e.hits > 3) ? 3 : e.hits));
            checkOutput("err", 32'(err), 32'(e.err));
            last_e   = e;
            hold_chk = 1;
          end
        end else if (cyc - acc_cyc > SYM + 5) begin
          checkOutput("frame_timeout", 32'(done), 32'd1);
          active = 0;
        end
      end else if (done) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        active  = 1;
        acc_cyc = cyc;
        k       = 0;
        cap     = '0;
      end
    end
  end

  function automatic logic [PW-1:0] rand_pat();
    logic [PW-1:0] p = '0;
    for (int i = 0; i < SYM; i++) begin
      logic [1:0] s = 2'($urandom_range(0, 3));
      p[2*i+1] = s[1];
      p[2*i]   = s[0];
    end
    return p;
  endfunction

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_pattern = '0;
    y1_stuck    = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // All a=1,b=1: S0/S2 alternation, four hits (saturates to 3 on the narrow counter)
    applyStimulus(16'hFFFF, 0, 0);
    waitDone();
    // Single a=1,b=0 leaves the detector in S1; recovery symbol must be a=1,b=0
    applyStimulus(16'h0002, 0, 0);
    waitDone();

    // Broken detector (y1 stuck low), then a clean frame clears err
    y1_stuck = 1'b1;
    applyStimulus(rand_pat(), 0, 0);
    waitDone();
    y1_stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(16'hB4E1, 0, 0);
    waitDone();

    // Reset while symbol 3 is on the wires
    applyStimulus(16'hFFFF, 0, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkIdle("abort");
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // cmd_valid held across two frames
    applyStimulus(16'h5AF3, 1, 0);
    applyStimulus(16'hFFFF, 0, 1);
    waitDone();

    for (int n = 0; n < 40; n++) begin
      y1_stuck = ($urandom_range(0, 3) == 0);
      applyStimulus(rand_pat(), 0, 0);
      waitDone();
      y1_stuck = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
